// File: rtl/aes_128_key_expand.sv
// aes_128_key_expand: iterative AES-128 key schedule, one round key per clock into an 11-entry read table.
// Optional AES_KEY_EXPAND_ZEROIZE_EN clears the table on reset and clears rounds 1..10 on every accepted load.
module aes_128_key_expand (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         busy,
   output logic         keys_valid,
   output logic         done,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);
   typedef enum logic {IDLE, EXPAND} state_t;
   state_t r_state, w_next;
   logic [127:0] r_rk [11];
   logic [3:0] r_rnd;
   logic r_valid, r_done;
   logic w_accept, w_step, w_last;
   logic [127:0] w_prev;
   logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] s;
      s = 8'h00;
      case (x)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5; 8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0; 8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc; 8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a; 8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0; 8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b; 8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85; 8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5; 8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17; 8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88; 8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c; 8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9; 8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6; 8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e; 8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94; 8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68; 8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      c = 8'h00;
      case (r)
         4'd1: c = 8'h01; 4'd2: c = 8'h02; 4'd3: c = 8'h04; 4'd4: c = 8'h08; 4'd5: c = 8'h10;
         4'd6: c = 8'h20; 4'd7: c = 8'h40; 4'd8: c = 8'h80; 4'd9: c = 8'h1b; 4'd10: c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   assign w_prev = r_rk[r_rnd - 4'd1];
   assign w_t = {sbox(w_prev[23:16]), sbox(w_prev[15:8]), sbox(w_prev[7:0]), sbox(w_prev[31:24])} ^ {rcon(r_rnd), 24'h0};
   assign w_n0 = w_prev[127:96] ^ w_t;
   assign w_n1 = w_prev[95:64] ^ w_n0;
   assign w_n2 = w_prev[63:32] ^ w_n1;
   assign w_n3 = w_prev[31:0] ^ w_n2;

   always_ff @(posedge clk)
      r_state <= reset ? IDLE : w_next;

   always_comb begin
      w_accept = (r_state == IDLE) && key_load;
      w_step = (r_state == EXPAND);
      w_last = w_step && (r_rnd == 4'd10);
      w_next = w_accept ? EXPAND : w_last ? IDLE : r_state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rnd <= 4'd0;
         r_valid <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         r_rnd <= w_accept ? 4'd1 : w_last ? 4'd0 : w_step ? r_rnd + 4'd1 : r_rnd;
         r_valid <= w_accept ? 1'b0 : w_last ? 1'b1 : r_valid;
      end
   end

   // Table has no reset path unless zeroization is built in.
   always_ff @(posedge clk) begin
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      if (reset) begin
         for (int i = 0; i < 11; i++) r_rk[i] <= '0;
      end else if (w_accept) begin
         r_rk[0] <= key_in;
         for (int i = 1; i < 11; i++) r_rk[i] <= '0;
      end else if (w_step) begin
         r_rk[r_rnd] <= {w_n0, w_n1, w_n2, w_n3};
      end
`else
      if (!reset && w_accept) r_rk[0] <= key_in;
      else if (!reset && w_step) r_rk[r_rnd] <= {w_n0, w_n1, w_n2, w_n3};
`endif
   end

   assign busy = (r_state == EXPAND);
   assign keys_valid = r_valid;
   assign done = r_done;
   assign rd_key = (rd_idx > 4'd10) ? '0 : r_rk[rd_idx];
endmodule

// File: tb/tb_aes_128_key_expand.sv
// tb_aes_128_key_expand: random and FIPS-197 key loads checked against a word-level key schedule model
// whose S-box is derived from GF(2^8) inversion; the read-back schedule also drives a reference AES decryption.
module tb_aes_128_key_expand;
   logic clk = 1'b0;
   logic reset, key_load, busy, keys_valid, done;
   logic [127:0] key_in, rd_key;
   logic [3:0] rd_idx;
   int n_chk = 0, n_fail = 0;
   logic [7:0] sb [256], isb [256];
   logic [127:0] m_rk [11], d_rk [11];

   aes_128_key_expand dut (.clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load), .busy(busy),
      .keys_valid(keys_valid), .done(done), .rd_idx(rd_idx), .rd_key(rd_key));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] v, s;
         v = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
         sb[x] = s;
         isb[s] = 8'(x);
      end
   endtask

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
      logic [7:0] s [16];
      logic [7:0] u [16];
      logic [127:0] st;
      st = ct ^ d_rk[10];
      for (int r = 9; r >= 0; r--) begin
         for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
         for (int c = 0; c < 4; c++) for (int j = 0; j < 4; j++) u[j+4*c] = isb[s[j+4*((c-j+4)%4)]];
         for (int i = 0; i < 16; i++) st[127-8*i -: 8] = u[i];
         st ^= d_rk[r];
         if (r > 0) begin
            for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
            for (int c = 0; c < 4; c++) for (int j = 0; j < 4; j++)
               u[j+4*c] = gmul(s[4*c+j], 8'h0e) ^ gmul(s[4*c+(j+1)%4], 8'h0b) ^ gmul(s[4*c+(j+2)%4], 8'h0d) ^ gmul(s[4*c+(j+3)%4], 8'h09);
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = u[i];
         end
      end
      return st;
   endfunction

   task automatic wait_valid(output int n);
      n = 0;
      while (!keys_valid && n < 30) begin
         tick();
         n++;
      end
   endtask

   // poke=1 raises key_load with a different key so that it is sampled at E3, while busy.
   task automatic run_key(input logic [127:0] k, input bit poke);
      int n;
      key_in = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      chk("busy_after_accept", busy, 1'b1);
      chk("valid_drop", keys_valid, 1'b0);
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      rd_idx = 4'd10;
      #1 chk("zeroize_on_load", rd_key, '0);
`endif
      n = 0;
      while (!keys_valid && n < 30) begin
         if (poke && n == 2) begin
            key_load = 1'b1;
            key_in = ~k;
         end
         tick();
         n++;
         key_load = 1'b0;
      end
      chk("latency", n, 10);
      chk("done_pulse", done, 1'b1);
      chk("busy_end", busy, 1'b0);
      tick();
      chk("done_low", done, 1'b0);
      chk("valid_hold", keys_valid, 1'b1);
      model_expand(k);
      for (int r = 10; r >= 0; r--) begin
         rd_idx = 4'(r);
         #1;
         d_rk[r] = rd_key;
         chk($sformatf("rk%0d", r), rd_key, m_rk[r]);
      end
   endtask

   initial begin
      int n;
      build_sbox();
      reset = 1'b1;
      key_load = 1'b0;
      key_in = '0;
      rd_idx = 4'd0;
      repeat (2) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", keys_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      reset = 1'b0;

      run_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
      chk("c1_rk1", d_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      chk("c1_rk10", d_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("c1_decrypt", inv_cipher(128'h69c4e0d86a7b0430d8cdb78070b4c55a), 128'h00112233445566778899aabbccddeeff);
      for (int i = 11; i < 16; i++) begin
         rd_idx = 4'(i);
         #1 chk($sformatf("rd_oob%0d", i), rd_key, '0);
      end

      run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
      chk("a1_rk1", d_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("a1_rk10", d_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_key(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
      chk("busy_load_ignored", d_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Reset at E5 together with a load request: reset must win.
      key_in = {$urandom, $urandom, $urandom, $urandom};
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      key_load = 1'b1;
      tick();
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_valid", keys_valid, 1'b0);
      chk("midrst_done", done, 1'b0);
      reset = 1'b0;
      key_load = 1'b0;
      tick();
      chk("midrst_load_dropped", busy, 1'b0);
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      for (int r = 0; r < 11; r++) begin
         rd_idx = 4'(r);
         #1 chk($sformatf("zeroize_rst%0d", r), rd_key, '0);
      end
`endif
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

      // key_load held high restarts at E11.
      key_in = {$urandom, $urandom, $urandom, $urandom};
      key_load = 1'b1;
      tick();
      wait_valid(n);
      chk("held_latency", n, 10);
      tick();
      chk("held_restart_busy", busy, 1'b1);
      chk("held_restart_valid", keys_valid, 1'b0);
      key_load = 1'b0;
      model_expand(key_in);
      wait_valid(n);
      chk("held_latency2", n, 10);
      rd_idx = 4'd10;
      #1 chk("held_rk10", rd_key, m_rk[10]);

      repeat (4) run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
